// File: rtl/demux_1_4_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_4_reg_if
//  Description : Upstream/downstream handshake bundle for the registered
//                1-to-4 stream demultiplexer. The master side is the
//                producer/consumer environment; the slave side is the demux.
//  Revision    : 1.0  initial release
// ============================================================================
interface demux_1_4_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic                 up_valid;
    logic                 up_ready;
    logic [WIDTH-1:0]     up_data;
    logic [1:0]           up_sel;
    logic [3:0]           down_valid;
    logic [3:0]           down_ready;
    logic [4*WIDTH-1:0]   down_data;
    logic [4*CNT_W-1:0]   down_cnt;

    modport master (
        output up_valid,
        output up_data,
        output up_sel,
        output down_ready,
        input  up_ready,
        input  down_valid,
        input  down_data,
        input  down_cnt
    );

    modport slave (
        input  up_valid,
        input  up_data,
        input  up_sel,
        input  down_ready,
        output up_ready,
        output down_valid,
        output down_data,
        output down_cnt
    );
endinterface
`default_nettype wire

// File: rtl/demux_1_4_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_4_reg
//  Description : Registered 1-to-4 stream demultiplexer. Each upstream word is
//                steered by its 2-bit select into a one-entry holding register
//                per channel; every channel drains through its own valid/ready
//                handshake and counts delivered words (wrapping counter).
//  Revision    : 1.0  initial release
// ============================================================================
module demux_1_4_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    demux_1_4_reg_if.slave    bus
);

    localparam int c_NUM_CH = 4;

    logic [WIDTH-1:0]    r_data [c_NUM_CH];
    logic [c_NUM_CH-1:0] r_full;
    logic [CNT_W-1:0]    r_cnt  [c_NUM_CH];

    logic                w_up_ready;
    logic [c_NUM_CH-1:0] w_accept;
    logic [c_NUM_CH-1:0] w_drain;

    // Upstream may proceed when the targeted slot is empty or is being emptied
    // this very cycle; deliberately independent of up_valid.
    always_comb begin
        w_up_ready = !r_full[bus.up_sel] || bus.down_ready[bus.up_sel];
    end

    // One-hot accept strobe for the channel selected by the current word.
    always_comb begin
        w_accept = '0;
        if (bus.up_valid && w_up_ready) begin
            w_accept[bus.up_sel] = 1'b1;
        end
    end

    assign w_drain = r_full & bus.down_ready;

    // Per-channel holding register, full flag and delivered-word counter.
    // A simultaneous drain and accept keeps the slot full (no bubble).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            for (int i = 0; i < c_NUM_CH; i++) begin
                r_data[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_CH; i++) begin
                if (w_accept[i]) begin
                    r_data[i] <= bus.up_data;
                end
                if (w_drain[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            r_full <= w_accept | (r_full & ~w_drain);
        end
    end

    assign bus.up_ready   = w_up_ready;
    assign bus.down_valid = r_full;

    generate
        for (genvar g = 0; g < c_NUM_CH; g++) begin : g_chan
            assign bus.down_data[g*WIDTH +: WIDTH] = r_data[g];
            assign bus.down_cnt[g*CNT_W +: CNT_W]  = r_cnt[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1_4_reg
//  Description : Directed self-checking bench for demux_1_4_reg with a short
//                randomised scoreboard phase at the end.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux_1_4_reg;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    demux_1_4_reg_if #(.WIDTH(4), .CNT_W(8)) bus ();

    demux_1_4_reg #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] s);
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        bus.up_sel   = s;
        #1;
    endtask

    function automatic logic [3:0] dd(input int ch);
        logic [15:0] v;
        v = bus.down_data;
        return v[ch*4 +: 4];
    endfunction

    function automatic logic [7:0] dc(input int ch);
        logic [31:0] v;
        v = bus.down_cnt;
        return v[ch*8 +: 8];
    endfunction

    logic [3:0] sbq [4][$];
    logic [7:0] mcnt [4];
    logic [3:0] vec;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.up_valid   = 1'b0;
        bus.up_data    = 4'h0;
        bus.up_sel     = 2'd0;
        bus.down_ready = 4'h0;
        step();
        step();
        rst = 1'b0;
        #1;

        // ---------------- reset state ----------------
        chk("rst_valid", 32'(bus.down_valid), 32'h0);
        chk("rst_data",  32'(bus.down_data),  32'h0);
        chk("rst_cnt",   32'(bus.down_cnt),   32'h0);
        for (int s = 0; s < 4; s++) begin
            bus.up_sel = 2'(s);
            #1;
            chk("rst_up_ready", 32'(bus.up_ready), 32'h1);
        end

        // ---------------- routing ----------------
        bus.down_ready = 4'hF;
        send(4'hA, 2'd0); chk("rt_rdy0", 32'(bus.up_ready), 32'h1);
        step(); chk("rt_v0", 32'(bus.down_valid), 32'h1); chk("rt_d0", 32'(dd(0)), 32'hA);
        send(4'h5, 2'd1);
        step(); chk("rt_v1", 32'(bus.down_valid), 32'h2); chk("rt_d1", 32'(dd(1)), 32'h5);
        send(4'hC, 2'd2);
        step(); chk("rt_v2", 32'(bus.down_valid), 32'h4); chk("rt_d2", 32'(dd(2)), 32'hC);
        send(4'h3, 2'd3);
        step(); chk("rt_v3", 32'(bus.down_valid), 32'h8); chk("rt_d3", 32'(dd(3)), 32'h3);
        bus.up_valid = 1'b0;
        step();
        chk("rt_idle_valid", 32'(bus.down_valid), 32'h0);
        chk("rt_cnt",        32'(bus.down_cnt),   32'h01010101);
        chk("rt_hold_data",  32'(bus.down_data),  32'h3C5A);

        // ---------------- stall isolation ----------------
        bus.down_ready = 4'b1011;
        send(4'h7, 2'd2); chk("st_rdy7", 32'(bus.up_ready), 32'h1);
        step(); chk("st_v7", 32'(bus.down_valid), 32'h4); chk("st_d7", 32'(dd(2)), 32'h7);
        send(4'h9, 2'd2); chk("st_blocked", 32'(bus.up_ready), 32'h0);
        step(); chk("st_held_v", 32'(bus.down_valid), 32'h4); chk("st_held_d", 32'(dd(2)), 32'h7);
        send(4'h1, 2'd0); chk("st_other_rdy", 32'(bus.up_ready), 32'h1);
        step(); chk("st_other_v", 32'(bus.down_valid), 32'h5); chk("st_other_d", 32'(dd(0)), 32'h1);
        bus.up_valid = 1'b0;
        step(); chk("st_ch0_drained", 32'(bus.down_valid), 32'h4); chk("st_cnt0", 32'(dc(0)), 32'h2);
        send(4'h9, 2'd2);
        bus.down_ready = 4'hF;
        #1;
        chk("st_release_rdy", 32'(bus.up_ready), 32'h1);
        step(); chk("st_swap_v", 32'(bus.down_valid), 32'h4); chk("st_swap_d", 32'(dd(2)), 32'h9);
        chk("st_swap_cnt2", 32'(dc(2)), 32'h2);
        bus.up_valid = 1'b0;
        step();
        chk("st_end_valid", 32'(bus.down_valid), 32'h0);
        chk("st_end_cnt",   32'(bus.down_cnt),   32'h01030102);

        // ---------------- same-channel back-to-back ----------------
        for (int k = 0; k < 16; k++) begin
            send(4'(k), 2'd1);
            chk("b2b_rdy", 32'(bus.up_ready), 32'h1);
            step();
            chk("b2b_valid", 32'(bus.down_valid), 32'h2);
            chk("b2b_data",  32'(dd(1)), 32'(k));
        end
        bus.up_valid = 1'b0;
        step();
        chk("b2b_cnt1", 32'(dc(1)), 32'h11);
        chk("b2b_idle", 32'(bus.down_valid), 32'h0);

        // ---------------- counter wrap on channel 3 (starts at 1) ----------------
        send(4'h0, 2'd3);
        for (int k = 0; k < 254; k++) step();
        step();
        bus.up_valid = 1'b0;
        step();
        chk("wrap_zero", 32'(dc(3)), 32'h0);
        send(4'h6, 2'd3);
        step();
        bus.up_valid = 1'b0;
        step();
        chk("wrap_one", 32'(dc(3)), 32'h1);

        // ---------------- reset mid-stream ----------------
        bus.down_ready = 4'h0;
        send(4'h6, 2'd0); step();
        send(4'hB, 2'd2); step();
        chk("mr_filled", 32'(bus.down_valid), 32'h5);
        rst = 1'b1;
        send(4'hF, 2'd1);
        step();
        rst = 1'b0;
        bus.up_valid = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.down_valid), 32'h0);
        chk("mr_cnt",   32'(bus.down_cnt),   32'h0);
        chk("mr_data",  32'(bus.down_data),  32'h0);
        bus.down_ready = 4'hF;
        send(4'hE, 2'd2);
        step(); chk("mr_next_v", 32'(bus.down_valid), 32'h4); chk("mr_next_d", 32'(dd(2)), 32'hE);
        bus.up_valid = 1'b0;
        step();
        chk("mr_next_cnt", 32'(bus.down_cnt), 32'h00010000);

        // ---------------- random traffic against per-channel queues ----------------
        mcnt[0] = 8'd0; mcnt[1] = 8'd0; mcnt[2] = 8'd1; mcnt[3] = 8'd0;
        for (int c = 0; c < 3000; c++) begin
            bus.up_valid   = 1'($urandom_range(0, 1));
            bus.up_sel     = 2'($urandom_range(0, 3));
            bus.up_data    = 4'($urandom_range(0, 15));
            bus.down_ready = 4'($urandom_range(0, 15));
            @(negedge clk);
            vec = bus.down_valid;
            for (int i = 0; i < 4; i++) begin
                chk("rnd_valid", 32'(vec[i]), 32'(sbq[i].size() != 0));
                if (sbq[i].size() != 0) begin
                    chk("rnd_data", 32'(dd(i)), 32'(sbq[i][0]));
                end
            end
            chk("rnd_up_ready", 32'(bus.up_ready),
                32'((sbq[bus.up_sel].size() == 0) || bus.down_ready[bus.up_sel]));
            for (int i = 0; i < 4; i++) begin
                if (vec[i] && bus.down_ready[i] && sbq[i].size() != 0) begin
                    void'(sbq[i].pop_front());
                    mcnt[i] = mcnt[i] + 8'd1;
                end
            end
            if (bus.up_valid && bus.up_ready) begin
                sbq[bus.up_sel].push_back(bus.up_data);
            end
            step();
        end
        bus.up_valid   = 1'b0;
        bus.down_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (sbq[i].size() != 0) mcnt[i] = mcnt[i] + 8'd1;
        end
        step();
        step();
        chk("rnd_final_valid", 32'(bus.down_valid), 32'h0);
        chk("rnd_final_cnt", 32'(bus.down_cnt), {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
